eth_rx_fcs_check: RTL and testbench
===================================

# eth_rx_fcs_check

Receive-side Ethernet FCS checker and stripper, the counterpart of the transmit CRC-32 generator. It sits between the GMII byte receiver (preamble/SFD already removed) and the RX frame buffer. It computes CRC-32 over every byte of the frame including the trailing 4-byte FCS and checks the result against the fixed CRC residue. It forwards the frame with the FCS removed and flags good/bad on the last byte.

## Interface
- DATALEN, 8, byte width of the data path; only 8 is supported.
- CRC_POLY, 32'hEDB88320, CRC-32 polynomial in reflected (LSB-first) form.
- CRC_RESIDUE, 32'hDEBB20E3, register value after a good frame plus FCS, before any final inversion.
- LEN_W, 12, width of the payload length output and counters' index.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  byte strobe; gaps within a frame are allowed.
- in_data  in  8  received byte, first-on-wire byte first.
- in_last  in  1  marks the final FCS byte; ignored unless in_valid=1.
- out_valid  out  1  payload byte strobe.
- out_data  out  8  payload byte.
- out_last  out  1  last payload byte of the frame.
- out_good  out  1  FCS correct; valid only with out_last.
- out_len  out  LEN_W  payload byte count (FCS excluded); valid with out_last.
- runt  out  1  one-cycle pulse for a frame of ≤4 bytes.
- good_cnt  out  16  count of good frames; saturating.
- bad_cnt  out  16  count of bad and runt frames; saturating.

## Operation
- CRC register: reset value 32'hFFFFFFFF. Per byte: XOR the byte into bits [7:0], then run 8 right-shifts, XORing CRC_POLY whenever the outgoing bit is 1. Input and output are not bit-reflected.
- Delay line: 4-byte shift register holding the most recent bytes. These may be FCS, so they are never forwarded until a later byte arrives.
- States:
  - IDLE: no bytes held.
  - FILL: 1–3 bytes held.
  - STREAM: 4 bytes held; each accepted byte pushes out the oldest byte.
- Transitions:
  - IDLE→FILL on the first accepted byte.
  - FILL→STREAM when the 4th byte is accepted.
  - Any state→IDLE on an accepted byte with in_last=1.
- Byte count: counts accepted bytes N. It saturates at 2^LEN_W−1. out_len = N−4.
- End of frame, on the accepted byte with in_last:
  - Compute the next CRC combinationally including that byte. out_good = (next CRC == CRC_RESIDUE).
  - Reload the CRC register to all ones, clear the delay line and clear the count.
- Runt: if in_last arrives with N≤4:
  - no out_valid is produced;
  - runt pulses for one cycle;
  - bad_cnt increments.
- Counters: good_cnt increments on out_last with out_good=1; bad_cnt increments on out_last with out_good=0, or on runt. Both hold at 16'hFFFF.
- No backpressure: the downstream block must accept every out_valid.

## Timing
- All outputs are registered. Reset values:
  - out_valid, out_last, out_good, runt = 0;
  - out_data = 8'h00, out_len = 0;
  - good_cnt, bad_cnt = 0;
  - state = IDLE, CRC register = all ones.
- Latency: accepting byte k (0-based, k≥4) in cycle t gives out_valid with byte k−4 in cycle t+1.
- The last payload byte (k = N−5) is emitted in the cycle after in_last is accepted, together with out_last, out_good and out_len.
- Counters update in the same cycle as out_last or runt is driven.
- Back-to-back frames: a byte accepted in the cycle right after in_last starts a new frame with a clean CRC; there is no dead cycle.
- in_valid=0 cycles hold all state. Outputs return to out_valid=0 in that cycle.
- rst asserted mid-frame: the partial frame is discarded. No out_last or runt is produced and the counters are cleared.

## Structure
- Shared package `eth_pkg`:
  - CRC32_POLY_REFL = 32'hEDB88320;
  - CRC32_RESIDUE = 32'hDEBB20E3;
  - CRC32_INIT = 32'hFFFFFFFF;
  - FCS_BYTES = 4;
  - the state enum (IDLE/FILL/STREAM).
- One combinational sub-module, `crc32_d8`: inputs crc_in[31:0] and data[7:0], output crc_out[31:0]. It is reusable by the TX side.

## Test plan
- Good frame: bytes 31..39 ("123456789") followed by FCS 26 39 F4 CB with in_last on CB → out_valid with 31..39. out_last on 39, out_good=1, out_len=9, good_cnt=1.
- Corrupt FCS: same frame with last byte CA → same 9 bytes out, out_good=0, bad_cnt=1.
- Runt: 3 bytes AA BB CC with in_last on CC → no out_valid, runt=1 for one cycle, bad_cnt=1.
- Gaps and back-to-back frames:
  - the good frame sent with in_valid deasserted every other cycle → identical output and flags;
  - then a second good frame starting the cycle after in_last → two out_last pulses, good_cnt=2.
- Reset mid-frame: rst after 6 bytes of the good frame, then the full good frame → only the second frame is reported; good_cnt=1, bad_cnt=0.
- Counter saturation: force bad_cnt near 16'hFFFF via 65,536 runts → it stays at 16'hFFFF.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types used by the RX FCS checker and TX CRC generator.
package eth_pkg;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int          FCS_BYTES       = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } rx_state_e;
endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 update for one byte, LSB-first (reflected) form.
module crc32_d8
  import eth_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY_REFL
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    crc_out = c;
  end
endmodule

// File: rtl/eth_rx_fcs_check.sv
// RX FCS checker/stripper: CRC over frame+FCS vs residue, 4-byte delay line hides the FCS.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int          DATALEN     = 8,
  parameter logic [31:0] CRC_POLY    = CRC32_POLY_REFL,
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE,
  parameter int          LEN_W       = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATALEN-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  output logic [DATALEN-1:0] out_data,
  output logic               out_last,
  output logic               out_good,
  output logic [LEN_W-1:0]   out_len,
  output logic               runt,
  output logic [15:0]        good_cnt,
  output logic [15:0]        bad_cnt
);
  rx_state_e state_q, state_d;

  logic [31:0]                           crc_q, crc_nxt;
  logic [FCS_BYTES-1:0][DATALEN-1:0]     dly_q;
  logic [LEN_W-1:0]                      cnt_q, cnt_inc;
  logic eof, fwd, is_runt, fcs_ok, good_inc, bad_inc;

  crc32_d8 #(.POLY(CRC_POLY)) u_crc (
    .crc_in (crc_q),
    .data   (in_data),
    .crc_out(crc_nxt)
  );

  always_comb begin
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    eof      = in_valid & in_last;
    // Only STREAM holds a full delay line, so only then does a new byte release one.
    fwd      = in_valid && (state_q == STREAM);
    is_runt  = eof && (cnt_inc <= LEN_W'(FCS_BYTES));
    fcs_ok   = (crc_nxt == CRC_RESIDUE);
    good_inc = fwd & eof & fcs_ok;
    bad_inc  = (fwd & eof & ~fcs_ok) | is_runt;
  end

  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      if (in_last) state_d = IDLE;
      else begin
        case (state_q)
          IDLE:    state_d = FILL;
          FILL:    if (cnt_q == LEN_W'(FCS_BYTES - 1)) state_d = STREAM;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC32_INIT;
      dly_q <= '0;
      cnt_q <= '0;
    end else if (in_valid) begin
      if (in_last) begin
        crc_q <= CRC32_INIT;
        dly_q <= '0;
        cnt_q <= '0;
      end else begin
        crc_q <= crc_nxt;
        dly_q <= {dly_q[FCS_BYTES-2:0], in_data};
        cnt_q <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_good  <= 1'b0;
      out_len   <= '0;
      runt      <= 1'b0;
    end else begin
      out_valid <= fwd;
      out_last  <= fwd & eof;
      out_good  <= good_inc;
      runt      <= is_runt;
      if (fwd) out_data <= dly_q[FCS_BYTES-1];
      if (fwd && eof) out_len <= cnt_inc - LEN_W'(FCS_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (good_inc && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 1'b1;
      if (bad_inc && bad_cnt != 16'hFFFF)   bad_cnt  <= bad_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check using directed frames with known CRC-32 FCS.
module tb_eth_rx_fcs_check;
  import eth_pkg::*;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic        good;
    logic [11:0] len;
  } exp_t;

  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_last = 0;
  logic [7:0]  in_data = 0;
  logic        out_valid, out_last, out_good, runt;
  logic [7:0]  out_data;
  logic [11:0] out_len;
  logic [15:0] good_cnt, bad_cnt;

  exp_t sb[$];
  int total = 0, bad = 0;
  int exp_good = 0, exp_bad = 0, exp_runt = 0, seen_runt = 0;

  eth_rx_fcs_check dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_good(out_good),
    .out_len(out_len), .runt(runt), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (runt === 1'b1) seen_runt++;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
        if (e.last) begin
          chk("out_good", out_good, e.good);
          chk("out_len", out_len, e.len);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    in_valid = v; in_data = d; in_last = l;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 8'h00, 0);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gap, input bit good);
    int n;
    exp_t e;
    n = f.size();
    for (int i = 0; i < n - 4; i++) begin
      e.data = f[i]; e.last = (i == n - 5); e.good = good; e.len = 12'(n - 4);
      sb.push_back(e);
    end
    if (n <= 4) begin
      exp_runt++;
      if (exp_bad < 16'hFFFF) exp_bad++;
    end else if (good) begin
      if (exp_good < 16'hFFFF) exp_good++;
    end else if (exp_bad < 16'hFFFF) exp_bad++;
    for (int i = 0; i < n; i++) begin
      drive(1, f[i], i == n - 1);
      if (gap) idle();
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_good_cnt"}, good_cnt, exp_good);
    chk({nm, "_bad_cnt"}, bad_cnt, exp_bad);
  endtask

  logic [7:0] good_f[$], corrupt_f[$], runt_f[$], one_f[$];

  initial begin
    exp_t e;
    good_f    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
    corrupt_f = good_f;
    corrupt_f[12] = 8'hCA;
    runt_f    = '{8'hAA, 8'hBB, 8'hCC};
    one_f     = '{8'h55};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_good", out_good, 0);
    chk("rst_runt", runt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_good_cnt", good_cnt, 0);
    chk("rst_bad_cnt", bad_cnt, 0);
    rst = 0;
    idle();

    send_frame(good_f, 0, 1);   idle(); chk_cnt("good");
    send_frame(corrupt_f, 0, 0); idle(); chk_cnt("corrupt");
    send_frame(runt_f, 0, 0);   idle(); chk_cnt("runt");
    chk("runt_pulses", seen_runt, exp_runt);

    send_frame(good_f, 1, 1);   idle(); chk_cnt("gap");
    send_frame(good_f, 0, 1);
    send_frame(good_f, 0, 1);   idle(); chk_cnt("b2b");

    // Mid-frame reset: bytes 0 and 1 escape before reset, rest is discarded.
    for (int i = 0; i < 6; i++) begin
      if (i < 2) begin
        e.data = good_f[i]; e.last = 0; e.good = 0; e.len = 0;
        sb.push_back(e);
      end
      drive(1, good_f[i], 0);
    end
    rst = 1; idle(); rst = 0;
    exp_good = 0; exp_bad = 0;
    chk_cnt("after_rst");
    send_frame(good_f, 0, 1);   idle(); chk_cnt("post_rst");

    for (int i = 0; i < 65538; i++) send_frame(one_f, 0, 0);
    idle();
    chk("sat_bad_cnt", bad_cnt, 16'hFFFF);
    chk_cnt("sat");
    send_frame(corrupt_f, 0, 0); idle(); chk_cnt("sat_hold");
    send_frame(good_f, 0, 1);    idle(); chk_cnt("sat_good");

    repeat (3) idle();
    chk("sb_empty", sb.size(), 0);
    chk("runt_total", seen_runt, exp_runt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
